// File: rtl/psg_stereo_mixer_if.sv
// psg_stereo_mixer_if: sample strobe, channel/route/volume controls and PCM/DAC outputs of the stereo mixer
// master drives ce_sample, ch_in, mode, pan_l, pan_r, vol, mute; slave returns pcm_l, pcm_r, pcm_valid, busy, overrun, audio_l, audio_r
interface psg_stereo_mixer_if #(
  parameter int CH = 3,
  parameter int IN_W = 8,
  parameter int OUT_W = 16
);
  logic ce_sample;
  logic [CH*IN_W-1:0] ch_in;
  logic [1:0] mode;
  logic [CH-1:0] pan_l;
  logic [CH-1:0] pan_r;
  logic [2:0] vol;
  logic mute;
  logic [OUT_W-1:0] pcm_l;
  logic [OUT_W-1:0] pcm_r;
  logic pcm_valid;
  logic busy;
  logic overrun;
  logic audio_l;
  logic audio_r;
  modport master (
    output ce_sample, ch_in, mode, pan_l, pan_r, vol, mute,
    input  pcm_l, pcm_r, pcm_valid, busy, overrun, audio_l, audio_r
  );
  modport slave (
    input  ce_sample, ch_in, mode, pan_l, pan_r, vol, mute,
    output pcm_l, pcm_r, pcm_valid, busy, overrun, audio_l, audio_r
  );
endinterface

// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer: serial stereo mixer of CH PSG channels with volume/mute and per-side first-order sigma-delta DAC
// clk_sys, reset (sync, active-high); bus_io (slave): strobe/levels/routing/volume in, registered PCM, status and 1-bit audio out
module psg_stereo_mixer #(
  parameter int CH = 3,
  parameter int IN_W = 8,
  parameter int OUT_W = 16,
  parameter logic [CH-1:0] MASK1_L = 3'b011,
  parameter logic [CH-1:0] MASK1_R = 3'b110,
  parameter logic [CH-1:0] MASK2_L = 3'b101,
  parameter logic [CH-1:0] MASK2_R = 3'b110
) (
  input logic clk_sys,
  input logic reset,
  psg_stereo_mixer_if.slave bus_io
);
  localparam int SUM_W = IN_W + $clog2(CH);
  localparam int IDX_W = $clog2(CH);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state_q, state_d;
  logic [CH*IN_W-1:0] ch_q, ch_d;
  logic [CH-1:0] mask_l_q, mask_l_d, mask_r_q, mask_r_d, eff_l, eff_r;
  logic [2:0] vol_q, vol_d;
  logic mute_q, mute_d;
  logic [SUM_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, ch_sel;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic pcm_valid_q, pcm_valid_d, overrun_q, overrun_d;
  logic [OUT_W:0] sd_l_q, sd_l_d, sd_r_q, sd_r_d;
  // left-justify the sum into OUT_W bits, then attenuate
  function automatic logic [OUT_W-1:0] scale(input logic [SUM_W-1:0] a, input logic [2:0] v);
    return (OUT_W'(a) << (OUT_W - SUM_W)) >> v;
  endfunction
  always_comb begin
    eff_l = bus_io.mode == 2'd0 ? '1 : bus_io.mode == 2'd1 ? MASK1_L : bus_io.mode == 2'd2 ? MASK2_L : bus_io.pan_l;
    eff_r = bus_io.mode == 2'd0 ? '1 : bus_io.mode == 2'd1 ? MASK1_R : bus_io.mode == 2'd2 ? MASK2_R : bus_io.pan_r;
    ch_sel = '0;
    for (int i = 0; i < CH; i++)
      if (idx_q == IDX_W'(i)) ch_sel = SUM_W'(ch_q[i*IN_W +: IN_W]);
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    mask_l_d = mask_l_q;
    mask_r_d = mask_r_q;
    vol_d = vol_q;
    mute_d = mute_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    idx_d = idx_q;
    pcm_l_d = pcm_l_q;
    pcm_r_d = pcm_r_q;
    pcm_valid_d = 1'b0;
    overrun_d = overrun_q | (bus_io.ce_sample & (state_q != IDLE));
    case (state_q)
      IDLE: if (bus_io.ce_sample) begin
        ch_d = bus_io.ch_in;
        mask_l_d = eff_l;
        mask_r_d = eff_r;
        vol_d = bus_io.vol;
        mute_d = bus_io.mute;
        acc_l_d = '0;
        acc_r_d = '0;
        idx_d = '0;
        state_d = ACC;
      end
      ACC: begin
        acc_l_d = acc_l_q + (mask_l_q[idx_q] ? ch_sel : '0);
        acc_r_d = acc_r_q + (mask_r_q[idx_q] ? ch_sel : '0);
        idx_d = idx_q + IDX_W'(1);
        state_d = idx_q == IDX_W'(CH - 1) ? OUT : ACC;
      end
      OUT: begin
        pcm_l_d = mute_q ? '0 : scale(acc_l_q, vol_q);
        pcm_r_d = mute_q ? '0 : scale(acc_r_q, vol_q);
        pcm_valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sd_l_d = {1'b0, sd_l_q[OUT_W-1:0]} + {1'b0, pcm_l_q};
    sd_r_d = {1'b0, sd_r_q[OUT_W-1:0]} + {1'b0, pcm_r_q};
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q <= '0;
      mask_l_q <= '0;
      mask_r_q <= '0;
      vol_q <= '0;
      mute_q <= 1'b0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      idx_q <= '0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      sd_l_q <= '0;
      sd_r_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      mask_l_q <= mask_l_d;
      mask_r_q <= mask_r_d;
      vol_q <= vol_d;
      mute_q <= mute_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      idx_q <= idx_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q <= overrun_d;
      sd_l_q <= sd_l_d;
      sd_r_q <= sd_r_d;
    end
  end
  assign bus_io.pcm_l = pcm_l_q;
  assign bus_io.pcm_r = pcm_r_q;
  assign bus_io.pcm_valid = pcm_valid_q;
  assign bus_io.busy = state_q != IDLE;
  assign bus_io.overrun = overrun_q;
  // the carry out of each phase accumulator is the bitstream
  assign bus_io.audio_l = sd_l_q[OUT_W];
  assign bus_io.audio_r = sd_r_q[OUT_W];
endmodule

// File: doc/psg_stereo_mixer.md
# psg_stereo_mixer

Parametrised stereo mixer and 1-bit DAC for multi-channel PSG audio. It takes CH unsigned channel levels and routes each to left, right or both outputs according to a selectable stereo mode. Channels are summed serially once per sample strobe, then scaled, attenuated and presented as registered PCM. Each side drives a first-order sigma-delta pin output. It replaces the fixed three-channel ABC/ACB mux plus separate per-side DAC instances in the board top levels.

## Interface
- CH, 3: number of input channels (2..8).
- IN_W, 8: width of each unsigned channel level.
- OUT_W, 16: PCM width; must be ≥ SUM_W = IN_W + clog2(CH).
- MASK1_L, 3'b011: left route mask for mode 1 (bit i = channel i; default A+B).
- MASK1_R, 3'b110: right route mask for mode 1 (default B+C).
- MASK2_L, 3'b101: left route mask for mode 2 (default A+C).
- MASK2_R, 3'b110: right route mask for mode 2 (default B+C).
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ce_sample  in  1  one-cycle sample strobe.
- ch_in  in  CH*IN_W  channel levels; channel i at bits [i*IN_W +: IN_W].
- mode  in  2  0 = mono (all channels to both sides), 1 = MASK1, 2 = MASK2, 3 = runtime masks.
- pan_l, pan_r  in  CH each  runtime route masks, used in mode 3.
- vol  in  3  attenuation as a right shift of 0..7 bits.
- mute  in  1  forces PCM to zero.
- pcm_l, pcm_r  out  OUT_W  registered unsigned PCM.
- pcm_valid  out  1  one-cycle pulse when PCM updates.
- busy  out  1  high while accumulating.
- overrun  out  1  sticky flag; set when ce_sample arrives while busy.
- audio_l, audio_r  out  1  sigma-delta bitstreams.

## Operation
- FSM states: IDLE, ACC, OUT.
- IDLE, on ce_sample:
  - Snapshot ch_in, the effective masks (chosen by mode), vol and mute.
  - Clear acc_l and acc_r (SUM_W bits each), set idx to 0, go to ACC.
- ACC, one channel per cycle:
  - acc_l += ch[idx] if mask_l[idx]; acc_r += ch[idx] if mask_r[idx].
  - idx increments; after idx = CH-1, go to OUT.
  - Sums cannot overflow, because SUM_W holds CH×(2^IN_W − 1).
- OUT:
  - pcm_x = mute ? 0 : ({acc_x, (OUT_W−SUM_W) zeros} >> vol).
  - Pulse pcm_valid, return to IDLE.
- Mode 0 uses all-ones masks for both sides.
- An empty mask yields 0 on that side.
- Inputs are snapshotted, so changing mode, pan, vol or mute mid-accumulation only affects the next sample.
- ce_sample while not in IDLE:
  - The strobe is ignored and overrun is set.
  - overrun clears only on reset.
- Sigma-delta, updated every clk_sys independently of the FSM:
  - sd_x (OUT_W+1 bits) = {1'b0, sd_x[OUT_W-1:0]} + pcm_x.
  - audio_x = sd_x[OUT_W] (the carry), registered.
- Reset values, all outputs 0:
  - pcm_l, pcm_r, pcm_valid, busy, overrun and audio_l, audio_r are 0.
  - FSM returns to IDLE; accumulators, idx and sigma-delta registers clear.
- Reset mid-ACC aborts the sample; no pcm_valid is produced.

## Timing
- busy is high from the cycle after ce_sample until the OUT cycle, inclusive.
- The ce_sample edge is cycle 0. ACC occupies cycles 1..CH and OUT is cycle CH+1.
- pcm_l, pcm_r and pcm_valid are visible after the edge ending cycle CH+1. Latency is CH+2 edges from the strobe to the new PCM value.
- Minimum ce_sample spacing is CH+2 cycles. A strobe exactly CH+2 cycles after the previous one is accepted.
- The sigma-delta sees a new pcm_x one cycle after it updates.
- Sigma-delta mean density is pcm_x / 2^OUT_W. Full scale (all ones) produces 1 on every cycle except one in 2^OUT_W.

## Test plan
- ABC mode, defaults, ch = {C=0x40, B=0x20, A=0x10}, vol 0:
  - Expect pcm_l = 0x30<<6 = 0x0C00 and pcm_r = 0x60<<6 = 0x1800.
  - pcm_valid pulses exactly 5 cycles after ce_sample.
- Mono, all channels 0xFF:
  - Expect acc = 0x2FD and pcm_l = pcm_r = 0xBF40.
  - Repeat with vol = 3: expect 0x17E8.
- Mode 3 with pan_l = 0, pan_r = 3'b111: expect pcm_l = 0.
  - Then apply mute = 1: the next sample gives 0 on both sides.
- Strobe spacing, CH = 3:
  - A second ce_sample 2 cycles after the first is ignored: overrun = 1, only one pcm_valid.
  - A strobe at spacing 5 is accepted.
- Mid-ACC changes:
  - Change mode and ch_in mid-ACC: the result matches the snapshot values.
  - Assert reset mid-ACC: no pcm_valid; all outputs 0 on the next cycle.
- Sigma-delta density, OUT_W = 16:
  - Hold pcm_l = 0x4000 for 2^16 cycles: exactly 16384 ones on audio_l.
  - Hold pcm = 0: audio stays 0.
